// File: rtl/stc_acc_tile_engine_if.sv
// Stream bundle for stc_acc_tile_engine.
// Carries the per-channel beat input (in_valid/in_ready/in_mult/in_psum)
// and the per-channel result output (out_valid/out_ready/out/out_ovf).
// Channel p, lane j sits at [p][j]. This is bit-identical to the flat
// packing [(p*N+j)*DW_DATA +: DW_DATA].
//   master : upstream multiplier array + downstream psum buffer side
//   slave  : the accumulation engine
interface stc_acc_tile_engine_if #(
  parameter int N       = 16,
  parameter int N_PE    = 4,
  parameter int DW_DATA = 16
);
  logic [N_PE-1:0]                       in_valid;
  logic [N_PE-1:0]                       in_ready;
  logic [N_PE-1:0][N-1:0][DW_DATA-1:0]   in_mult;
  logic [N_PE-1:0][N-1:0][DW_DATA-1:0]   in_psum;
  logic [N_PE-1:0]                       out_valid;
  logic [N_PE-1:0]                       out_ready;
  logic [N_PE-1:0][N-1:0][DW_DATA-1:0]   out;
  logic [N_PE-1:0]                       out_ovf;

  modport master (
    output in_valid, in_mult, in_psum, out_ready,
    input  in_ready, out_valid, out, out_ovf
  );

  modport slave (
    input  in_valid, in_mult, in_psum, out_ready,
    output in_ready, out_valid, out, out_ovf
  );
endinterface

// File: rtl/stc_acc_tile_engine.sv
// Multi-PE partial-sum accumulation engine.
// There are N_PE independent channels, each N lanes wide. The first beat of a
// tile seeds each lane with psum + mult. Each following beat adds mult. After
// the latched k_len beats, the channel presents the narrowed lanes on
// out_valid/out_ready.
// Ports:
//   clk, reset  rising-edge clock, synchronous active-high reset
//   cfg_k_len   products per tile (0 behaves as 1), latched at tile start
//   cfg_sat     1 = saturate on narrowing, 0 = wrap; latched at tile start
//   acc_clr     per-channel abort back to IDLE (highest priority)
//   bus         stream bundle (slave side), see stc_acc_tile_engine_if

// One lane: wide accumulator plus narrowing to DW_DATA.
module stc_acc_tile_lane #(
  parameter int DW_DATA = 16,
  parameter int DW_ACC  = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               load,
  input  logic               add,
  input  logic               sat,
  input  logic               show,
  input  logic [DW_DATA-1:0] psum,
  input  logic [DW_DATA-1:0] mult,
  output logic [DW_DATA-1:0] res,
  output logic               ovf
);
  logic [DW_ACC-1:0]         acc, psum_x, mult_x;
  logic [DW_ACC-DW_DATA:0]   top;
  logic                      in_range;
  logic [DW_DATA-1:0]        narrow;

  assign psum_x = {{(DW_ACC-DW_DATA){psum[DW_DATA-1]}}, psum};
  assign mult_x = {{(DW_ACC-DW_DATA){mult[DW_DATA-1]}}, mult};

  always_ff @(posedge clk) begin
    if (reset || clr)  acc <= '0;
    else if (load)     acc <= psum_x + mult_x;
    else if (add)      acc <= acc + mult_x;
  end

  // The value fits DW_DATA iff everything from the narrow sign bit upward
  // is a pure sign extension.
  assign top      = acc[DW_ACC-1:DW_DATA-1];
  assign in_range = (&top) | ~(|top);

  always_comb begin
    narrow = acc[DW_DATA-1:0];
    if (!in_range && sat)
      narrow = acc[DW_ACC-1] ? {1'b1, {(DW_DATA-1){1'b0}}}
                             : {1'b0, {(DW_DATA-1){1'b1}}};
  end

  // The result is driven only while it is being presented. Otherwise it is 0.
  assign res = show ? narrow : '0;
  assign ovf = show & ~in_range;
endmodule

// One PE channel: tile FSM plus N lanes.
module stc_acc_tile_ch #(
  parameter int N       = 16,
  parameter int DW_DATA = 16,
  parameter int DW_ACC  = 24,
  parameter int CW      = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [CW-1:0]              cfg_k_len,
  input  logic                       cfg_sat,
  input  logic                       acc_clr,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N-1:0][DW_DATA-1:0]  in_mult,
  input  logic [N-1:0][DW_DATA-1:0]  in_psum,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N-1:0][DW_DATA-1:0]  out,
  output logic                       out_ovf
);
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, k_q, k_eff, cnt_inc;
  logic            sat_q, accept, load, add;
  logic [N-1:0]    lane_ovf;

  assign k_eff     = (cfg_k_len == '0) ? CW'(1) : cfg_k_len;
  assign cnt_inc   = cnt_q + CW'(1);
  assign in_ready  = !reset && (state_q != DONE);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign out_ovf   = |lane_ovf;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    add     = 1'b0;
    if (acc_clr) begin
      // An abort discards any beat offered in the same cycle.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          load    = 1'b1;
          state_d = (k_eff <= CW'(1)) ? DONE : ACC;
        end
        ACC: if (accept) begin
          add = 1'b1;
          if (cnt_inc == k_q) state_d = DONE;
        end
        DONE: if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Tile config is captured on the first beat, so later cfg changes only
  // affect the next tile.
  always_ff @(posedge clk) begin
    if (reset || acc_clr) begin
      cnt_q <= '0;
      k_q   <= '0;
      sat_q <= 1'b0;
    end else if (load) begin
      cnt_q <= CW'(1);
      k_q   <= k_eff;
      sat_q <= cfg_sat;
    end else if (add) begin
      cnt_q <= cnt_inc;
    end
  end

  for (genvar j = 0; j < N; j++) begin : g_lane
    stc_acc_tile_lane #(.DW_DATA(DW_DATA), .DW_ACC(DW_ACC)) u_lane (
      .clk   (clk),
      .reset (reset),
      .clr   (acc_clr),
      .load  (load),
      .add   (add),
      .sat   (sat_q),
      .show  (out_valid),
      .psum  (in_psum[j]),
      .mult  (in_mult[j]),
      .res   (out[j]),
      .ovf   (lane_ovf[j])
    );
  end
endmodule

module stc_acc_tile_engine #(
  parameter int N       = 16,
  parameter int N_PE    = 4,
  parameter int DW_DATA = 16,
  parameter int DW_ACC  = 24,
  parameter int CW      = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [CW-1:0]          cfg_k_len,
  input  logic                   cfg_sat,
  input  logic [N_PE-1:0]        acc_clr,
  stc_acc_tile_engine_if.slave   bus
);
  logic [N_PE-1:0]                     rdy, vld, ovf;
  logic [N_PE-1:0][N-1:0][DW_DATA-1:0] res;

  assign bus.in_ready  = rdy;
  assign bus.out_valid = vld;
  assign bus.out_ovf   = ovf;
  assign bus.out       = res;

  for (genvar p = 0; p < N_PE; p++) begin : g_ch
    stc_acc_tile_ch #(
      .N(N), .DW_DATA(DW_DATA), .DW_ACC(DW_ACC), .CW(CW)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .cfg_k_len (cfg_k_len),
      .cfg_sat   (cfg_sat),
      .acc_clr   (acc_clr[p]),
      .in_valid  (bus.in_valid[p]),
      .in_ready  (rdy[p]),
      .in_mult   (bus.in_mult[p]),
      .in_psum   (bus.in_psum[p]),
      .out_valid (vld[p]),
      .out_ready (bus.out_ready[p]),
      .out       (res[p]),
      .out_ovf   (ovf[p])
    );
  end
endmodule

// File: tb/tb_stc_acc_tile_engine.sv
module tb_stc_acc_tile_engine;
  localparam int N = 16, N_PE = 4, DW = 16, DA = 24, CW = 4;
  localparam int VW = N * DW;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [CW-1:0]   cfg_k_len = '0;
  logic            cfg_sat = 1'b0;
  logic [N_PE-1:0] acc_clr = '0;

  stc_acc_tile_engine_if #(.N(N), .N_PE(N_PE), .DW_DATA(DW)) bus();

  stc_acc_tile_engine #(.N(N), .N_PE(N_PE), .DW_DATA(DW), .DW_ACC(DA), .CW(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_k_len (cfg_k_len),
    .cfg_sat   (cfg_sat),
    .acc_clr   (acc_clr),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  // Behavioural model: per channel, the number of beats taken in the open
  // tile, the tile length/sat captured at its start, the exact integer lane
  // sums, and whether a finished result is waiting to be consumed.
  int     mbeats [N_PE];
  int     mk     [N_PE];
  bit     msat   [N_PE];
  bit     mhave  [N_PE];
  longint msum   [N_PE][N];

  initial begin
    for (int p = 0; p < N_PE; p++) begin
      mbeats[p] = 0; mk[p] = 1; msat[p] = 1'b0; mhave[p] = 1'b0;
      for (int j = 0; j < N; j++) msum[p][j] = 0;
    end
  end

  function automatic longint sx(input logic [DW-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic bit oob(input longint s);
    return (s > (longint'(1) <<< (DW-1)) - 1) || (s < -(longint'(1) <<< (DW-1)));
  endfunction

  function automatic logic [DW-1:0] nar(input longint s, input bit sat);
    if (oob(s) && sat) return (s > 0) ? DW'((longint'(1) <<< (DW-1)) - 1) : DW'(longint'(1) <<< (DW-1));
    return s[DW-1:0];
  endfunction

  function automatic logic [VW-1:0] rep(input logic [DW-1:0] v);
    return {N{v}};
  endfunction

  task automatic chk1(input string nm, input int p, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s ch%0d got=%0b exp=%0b t=%0t", nm, p, got, exp, $time);
    end
  endtask

  task automatic chkv(input string nm, input int p, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s ch%0d got=%h exp=%h t=%0t", nm, p, got, exp, $time);
    end
  endtask

  // Model update on the same edge that the DUT samples.
  always @(posedge clk) begin
    for (int p = 0; p < N_PE; p++) begin
      int b; int k; bit h; bit st; longint s [N];
      b = mbeats[p]; k = mk[p]; h = mhave[p]; st = msat[p];
      for (int j = 0; j < N; j++) s[j] = msum[p][j];
      if (reset || acc_clr[p]) begin
        b = 0; h = 1'b0;
        for (int j = 0; j < N; j++) s[j] = 0;
      end else if (h) begin
        if (bus.out_ready[p]) h = 1'b0;
      end else if (bus.in_valid[p]) begin
        if (b == 0) begin
          k  = (cfg_k_len == '0) ? 1 : int'(cfg_k_len);
          st = cfg_sat;
          for (int j = 0; j < N; j++) s[j] = sx(bus.in_psum[p][j]) + sx(bus.in_mult[p][j]);
        end else begin
          for (int j = 0; j < N; j++) s[j] = s[j] + sx(bus.in_mult[p][j]);
        end
        b++;
        if (b == k) begin h = 1'b1; b = 0; end
      end
      mbeats[p] <= b; mk[p] <= k; mhave[p] <= h; msat[p] <= st;
      for (int j = 0; j < N; j++) msum[p][j] <= s[j];
    end
  end

  // Compare process: every channel, every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int p = 0; p < N_PE; p++) begin
        logic [N-1:0][DW-1:0] eo;
        logic eovf;
        eovf = 1'b0;
        for (int j = 0; j < N; j++) begin
          eo[j] = mhave[p] ? nar(msum[p][j], msat[p]) : '0;
          if (mhave[p] && oob(msum[p][j])) eovf = 1'b1;
        end
        chk1("in_ready", p, bus.in_ready[p], !mhave[p] && !reset);
        chk1("out_valid", p, bus.out_valid[p], mhave[p]);
        chkv("out", p, bus.out[p], eo);
        chk1("out_ovf", p, bus.out_ovf[p], eovf);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_lanes(input int ch, input logic [DW-1:0] ps, input logic [DW-1:0] m);
    for (int j = 0; j < N; j++) begin
      bus.in_psum[ch][j] = ps;
      bus.in_mult[ch][j] = m;
    end
  endtask

  // Offer one beat on ch and hold it until accepted. Called and returns just
  // after a rising edge.
  task automatic send(input int ch, input logic [DW-1:0] ps, input logic [DW-1:0] m);
    logic took;
    took = 1'b0;
    set_lanes(ch, ps, m);
    bus.in_valid[ch] = 1'b1;
    for (int i = 0; i < 20 && !took; i++) begin
      @(negedge clk);
      took = bus.in_ready[ch];
      @(posedge clk); #1;
    end
    bus.in_valid[ch] = 1'b0;
    chk1("send_accept", ch, took, 1'b1);
  endtask

  task automatic pop(input int ch);
    bus.out_ready[ch] = 1'b1;
    tick();
    bus.out_ready[ch] = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int nclr;
    bus.in_valid = '0; bus.out_ready = '0;
    bus.in_mult = '0; bus.in_psum = '0;
    tick();
    chk_en = 1'b1;
    tick();
    // Reset state
    @(negedge clk);
    chk1("rst_in_ready", 0, bus.in_ready[0], 1'b0);
    chk1("rst_out_valid", 0, bus.out_valid[0], 1'b0);
    chkv("rst_out", 0, bus.out[0], '0);
    tick();
    reset = 1'b0;
    tick();

    // 1: k=3, psum 5, mults 1,2,3 back to back -> 11
    cfg_k_len = 4'd3; cfg_sat = 1'b1;
    send(0, 16'd5, 16'd1);
    send(0, 16'd0, 16'd2);
    send(0, 16'd0, 16'd3);
    @(negedge clk);
    chk1("t1_valid", 0, bus.out_valid[0], 1'b1);
    chkv("t1_out", 0, bus.out[0], rep(16'd11));
    chk1("t1_ovf", 0, bus.out_ovf[0], 1'b0);
    pop(0);

    // 2: k=1, 7 + -2 = 5, held through a 4-cycle stall with in_valid high
    cfg_k_len = 4'd1;
    send(0, 16'd7, 16'hFFFE);
    bus.in_valid[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chkv("t2_hold_out", 0, bus.out[0], rep(16'd5));
      chk1("t2_hold_ready", 0, bus.in_ready[0], 1'b0);
      chk1("t2_hold_valid", 0, bus.out_valid[0], 1'b1);
      tick();
    end
    bus.in_valid[0] = 1'b0;
    pop(0);

    // 3: positive overflow, saturating then wrapping
    cfg_k_len = 4'd2; cfg_sat = 1'b1;
    send(0, 16'h7FF0, 16'h0020);
    send(0, 16'h0000, 16'h0020);
    @(negedge clk);
    chkv("t3_sat_out", 0, bus.out[0], rep(16'h7FFF));
    chk1("t3_sat_ovf", 0, bus.out_ovf[0], 1'b1);
    cfg_sat = 1'b0;
    pop(0);
    send(0, 16'h7FF0, 16'h0020);
    send(0, 16'h0000, 16'h0020);
    @(negedge clk);
    chkv("t3_wrap_out", 0, bus.out[0], rep(16'h8030));
    chk1("t3_wrap_ovf", 0, bus.out_ovf[0], 1'b1);
    pop(0);

    // 4: negative clamp
    cfg_k_len = 4'd1; cfg_sat = 1'b1;
    send(0, 16'h8000, 16'hFFFF);
    @(negedge clk);
    chkv("t4_out", 0, bus.out[0], rep(16'h8000));
    chk1("t4_ovf", 0, bus.out_ovf[0], 1'b1);
    pop(0);

    // 5: all channels busy with random gaps, stalls and shifting cfg; abort ch1 mid-tile
    nclr = 0;
    for (int c = 0; c < 400; c++) begin
      bit fire;
      fire = 1'b0;
      cfg_k_len = CW'($urandom_range(0, 5));
      cfg_sat = 1'($urandom_range(0, 1));
      for (int p = 0; p < N_PE; p++) begin
        bus.in_valid[p] = ($urandom_range(0, 2) != 0);
        bus.out_ready[p] = 1'($urandom_range(0, 1));
        for (int j = 0; j < N; j++) begin
          bus.in_mult[p][j] = (j < 4) ? DW'($urandom_range(0, 40)) : DW'($urandom);
          bus.in_psum[p][j] = DW'($urandom);
        end
      end
      if (nclr < 3 && c > 20 && mbeats[1] > 0) begin
        acc_clr[1] = 1'b1;
        fire = 1'b1;
        nclr++;
      end
      tick();
      acc_clr = '0;
      if (fire) begin
        @(negedge clk);
        chk1("t5_clr_valid", 1, bus.out_valid[1], 1'b0);
        chk1("t5_clr_ready", 1, bus.in_ready[1], 1'b1);
        chkv("t5_clr_out", 1, bus.out[1], '0);
      end
    end
    chk1("t5_clr_seen", 1, nclr > 0, 1'b1);
    bus.in_valid = '0;
    bus.out_ready = '1;
    repeat (3) tick();
    bus.out_ready = '0;

    // 6: reset in the middle of a tile, then a clean tile
    cfg_k_len = 4'd5; cfg_sat = 1'b1;
    send(0, 16'd1, 16'd1);
    send(0, 16'd0, 16'd1);
    set_lanes(0, 16'd0, 16'd1);
    bus.in_valid[0] = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    chk1("t6_rst_ready", 0, bus.in_ready[0], 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.in_valid[0] = 1'b0;
    @(negedge clk);
    chk1("t6_post_valid", 0, bus.out_valid[0], 1'b0);
    chkv("t6_post_out", 0, bus.out[0], '0);
    chk1("t6_post_ovf", 0, bus.out_ovf[0], 1'b0);
    @(posedge clk); #1;
    cfg_k_len = 4'd2;
    send(0, 16'd100, 16'd3);
    send(0, 16'd0, 16'd4);
    @(negedge clk);
    chk1("t6_valid", 0, bus.out_valid[0], 1'b1);
    chkv("t6_out", 0, bus.out[0], rep(16'd107));
    pop(0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
